// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encodings and frame constants.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering TX bytes; wrap pointers carry an extra MSB
// so full and empty can be told apart.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             full_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_nxt  = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_nxt  = rd_ptr + {{AW{1'b0}}, do_pop};

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Look-ahead full lets the owner register tx_ready without a cycle of lag.
  assign full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
  assign dout     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_master.sv
// UART transmitter: buffered bytes are framed as start, 8 data bits LSB first,
// optional even parity and stop, with back-to-back frames and no idle gap.
module uart_master
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 u_tx,
  output logic                 u_tx_done,
  output logic                 tx_busy
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = (CLKS_PER_BIT >= 2) ? BW'(CLKS_PER_BIT - 2) : '0;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  tx_state_e            state;
  logic [BW-1:0]        baud_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic                 par;

  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full, fifo_empty, fifo_full_nxt;
  logic                 push, pop, bit_done, can_start, enter_stop, done_set;

  assign push      = tx_valid && tx_ready;
  assign bit_done  = (baud_cnt == BAUD_LAST);
  assign can_start = !fifo_empty && en_tx;
  assign pop       = can_start && ((state == IDLE) || (state == STOP && bit_done));

  assign enter_stop = bit_done &&
                      ((state == DATA && bit_cnt == LAST_BIT && PARITY_EN == 0) ||
                       (state == PARITY));
  // Done is registered, so it is raised one edge ahead of the final stop cycle.
  assign done_set = (CLKS_PER_BIT == 1) ? enter_stop
                                        : (state == STOP && baud_cnt == BAUD_PRE);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .din      (tx_data),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .full_nxt (fifo_full_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) tx_ready <= 1'b1;
    else        tx_ready <= !fifo_full_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      par       <= 1'b0;
      u_tx      <= 1'b1;
      u_tx_done <= 1'b0;
      tx_busy   <= 1'b0;
    end else begin
      u_tx_done <= done_set;
      case (state)
        IDLE: begin
          if (pop) begin
            sh       <= fifo_dout;
            par      <= even_parity(fifo_dout);
            u_tx     <= 1'b0;
            baud_cnt <= '0;
            tx_busy  <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            u_tx     <= sh[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                u_tx  <= par;
                state <= PARITY;
              end else begin
                u_tx  <= 1'b1;
                state <= STOP;
              end
            end else begin
              sh      <= sh >> 1;
              u_tx    <= sh[1];
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            u_tx     <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              sh    <= fifo_dout;
              par   <= even_parity(fifo_dout);
              u_tx  <= 1'b0;
              state <= START;
            end else begin
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          u_tx    <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
